// File: rtl/awg_pkg.sv
// Shared constants and types for the multi-channel waveform generator.
package awg_pkg;

    // Command opcodes carried in the upper nibble of the frame header
    localparam logic [3:0] OP_TYPE   = 4'h1;
    localparam logic [3:0] OP_FREQ   = 4'h2;
    localparam logic [3:0] OP_AMP    = 4'h3;
    localparam logic [3:0] OP_OFFSET = 4'h4;
    localparam logic [3:0] OP_COMMIT = 4'h5;
    localparam logic [3:0] OP_PHRST  = 4'h6;

    // Channel field value addressing every channel at once
    localparam logic [3:0] CH_BCAST = 4'hF;

    // Frame geometry: header, data MSB, data LSB, checksum
    localparam int unsigned FRAME_LEN    = 4;
    localparam int unsigned FRAME_DATA_W = 16;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_DC     = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DMSB = 2'd1,
        ST_DLSB = 2'd2,
        ST_CHK  = 2'd3
    } parse_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] chan;
    } hdr_t;

    typedef struct packed {
        hdr_t                    hdr;
        logic [FRAME_DATA_W-1:0] data;
    } cmd_t;

    // Frame checksum: XOR of the three payload bytes
    function automatic logic [7:0] frame_csum(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2);
        return b0 ^ b1 ^ b2;
    endfunction

endpackage

// File: rtl/awg_if.sv
// Command byte stream in, per-channel samples and status pulses out.
interface awg_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 10
);
    logic [7:0]               uart_data;
    logic                     data_valid;
    logic [NUM_CH*DATA_W-1:0] waveform_data;
    logic [NUM_CH-1:0]        phase_wrap;
    logic                     cmd_ack;
    logic                     frame_err;

    modport master (
        output uart_data, data_valid,
        input  waveform_data, phase_wrap, cmd_ack, frame_err
    );

    modport slave (
        input  uart_data, data_valid,
        output waveform_data, phase_wrap, cmd_ack, frame_err
    );
endinterface

// File: rtl/awg_multi_core_channel.sv
// One waveform channel: shadow/active settings, phase accumulator and a
// two-stage shape/scale/offset pipeline.
module awg_channel
    import awg_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned FREQ_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_type,
    input  logic                    wr_freq,
    input  logic                    wr_amp,
    input  logic                    wr_off,
    input  logic [FRAME_DATA_W-1:0] wr_data,
    input  logic                    commit,
    input  logic                    phase_clr,
    output logic [DATA_W-1:0]       sample,
    output logic                    wrap
);

    localparam int unsigned ACC_W  = FREQ_W + 8;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SAT_W  = DATA_W + 1;

    wave_e              type_sh_q, type_sh_d, type_act_q, type_act_d;
    logic [FREQ_W-1:0]  freq_sh_q, freq_sh_d, freq_act_q, freq_act_d;
    logic [DATA_W-1:0]  amp_sh_q, amp_sh_d, amp_act_q, amp_act_d;
    logic [DATA_W-1:0]  off_sh_q, off_sh_d, off_act_q, off_act_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               wrap_q, wrap_d;
    logic [DATA_W-1:0]  s1_q, s1_d;
    logic [DATA_W-1:0]  off1_q, off1_d;
    logic [DATA_W-1:0]  out_q, out_d;

    logic [SUM_W-1:0]   add_c;
    logic [DATA_W-1:0]  phase_c;
    logic [DATA_W-1:0]  raw_c;
    logic [PROD_W-1:0]  prod_c;
    logic [SAT_W-1:0]   sat_c;

    // Settings registers and phase accumulator next state
    always_comb begin
        type_sh_d  = type_sh_q;
        freq_sh_d  = freq_sh_q;
        amp_sh_d   = amp_sh_q;
        off_sh_d   = off_sh_q;
        type_act_d = type_act_q;
        freq_act_d = freq_act_q;
        amp_act_d  = amp_act_q;
        off_act_d  = off_act_q;

        if (wr_type) type_sh_d = wave_e'(wr_data[1:0]);
        if (wr_freq) freq_sh_d = FREQ_W'(wr_data);
        if (wr_amp)  amp_sh_d  = DATA_W'(wr_data);
        if (wr_off)  off_sh_d  = DATA_W'(wr_data);

        if (commit) begin
            type_act_d = type_sh_q;
            freq_act_d = freq_sh_q;
            amp_act_d  = amp_sh_q;
            off_act_d  = off_sh_q;
        end

        // Carry out of the accumulator is the wrap event; a phase clear wins
        add_c  = SUM_W'(acc_q) + SUM_W'(freq_act_q);
        acc_d  = phase_clr ? '0 : add_c[ACC_W-1:0];
        wrap_d = add_c[ACC_W] & ~phase_clr;
    end

    // Stage 1 shapes and scales, stage 2 adds offset with saturation
    always_comb begin
        phase_c = acc_q[ACC_W-1 -: DATA_W];
        raw_c   = '0;
        unique case (type_act_q)
            WAVE_SQUARE: raw_c = phase_c[DATA_W-1] ? '1 : '0;
            WAVE_SAW:    raw_c = phase_c;
            WAVE_TRI:    raw_c = phase_c[DATA_W-1] ? ~{phase_c[DATA_W-2:0], 1'b0}
                                                   :  {phase_c[DATA_W-2:0], 1'b0};
            WAVE_DC:     raw_c = '1;
            default:     raw_c = '0;
        endcase
        prod_c = PROD_W'(raw_c) * (PROD_W'(amp_act_q) + PROD_W'(1));
        s1_d   = DATA_W'(prod_c >> DATA_W);
        off1_d = off_act_q;
        sat_c  = SAT_W'(s1_q) + SAT_W'(off1_q);
        out_d  = sat_c[DATA_W] ? '1 : sat_c[DATA_W-1:0];
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            type_sh_q  <= WAVE_SQUARE;
            freq_sh_q  <= '0;
            amp_sh_q   <= '0;
            off_sh_q   <= '0;
            type_act_q <= WAVE_SQUARE;
            freq_act_q <= '0;
            amp_act_q  <= '0;
            off_act_q  <= '0;
            acc_q      <= '0;
            wrap_q     <= 1'b0;
            s1_q       <= '0;
            off1_q     <= '0;
            out_q      <= '0;
        end else begin
            type_sh_q  <= type_sh_d;
            freq_sh_q  <= freq_sh_d;
            amp_sh_q   <= amp_sh_d;
            off_sh_q   <= off_sh_d;
            type_act_q <= type_act_d;
            freq_act_q <= freq_act_d;
            amp_act_q  <= amp_act_d;
            off_act_q  <= off_act_d;
            acc_q      <= acc_d;
            wrap_q     <= wrap_d;
            s1_q       <= s1_d;
            off1_q     <= off1_d;
            out_q      <= out_d;
        end
    end

    assign sample = out_q;
    assign wrap   = wrap_q;

endmodule

// File: rtl/awg_multi_core.sv
// Multi-channel AWG: byte-stream command parser driving NUM_CH channels.
module awg_multi_core
    import awg_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned FREQ_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    awg_if.slave bus
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    parse_e             state_q, state_d;
    hdr_t               hdr_q, hdr_d;
    logic [7:0]         dmsb_q, dmsb_d;
    logic [7:0]         dlsb_q, dlsb_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    cmd_t               cmd_c;
    logic               op_ok_c, chan_ok_c, csum_ok_c, exec_c;
    logic [NUM_CH-1:0]  wr_type_c, wr_freq_c, wr_amp_c, wr_off_c, phase_clr_c;
    logic               commit_c;

    logic [NUM_CH*DATA_W-1:0] wave_w;
    logic [NUM_CH-1:0]        wrap_w;

    // Frame validation against the byte currently presented in CHK
    always_comb begin
        cmd_c     = '{hdr: hdr_q, data: {dmsb_q, dlsb_q}};
        op_ok_c   = (hdr_q.opcode >= OP_TYPE) && (hdr_q.opcode <= OP_PHRST);
        chan_ok_c = (hdr_q.opcode == OP_COMMIT) || (hdr_q.chan == CH_BCAST) ||
                    (32'(hdr_q.chan) < NUM_CH);
        csum_ok_c = frame_csum(hdr_q, dmsb_q, dlsb_q) == bus.uart_data;
    end

    // Parser next state, status pulses and inter-byte timeout
    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        dmsb_d  = dmsb_q;
        dlsb_d  = dlsb_q;
        idle_d  = idle_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        exec_c  = 1'b0;

        unique case (state_q)
            ST_HDR: if (bus.data_valid) begin
                hdr_d   = hdr_t'(bus.uart_data);
                state_d = ST_DMSB;
            end
            ST_DMSB: if (bus.data_valid) begin
                dmsb_d  = bus.uart_data;
                state_d = ST_DLSB;
            end
            ST_DLSB: if (bus.data_valid) begin
                dlsb_d  = bus.uart_data;
                state_d = ST_CHK;
            end
            ST_CHK: if (bus.data_valid) begin
                state_d = ST_HDR;
                if (csum_ok_c && op_ok_c && chan_ok_c) begin
                    exec_c = 1'b1;
                    ack_d  = 1'b1;
                end else begin
                    err_d  = 1'b1;
                end
            end
            default: state_d = ST_HDR;
        endcase

        // A byte in the expiry cycle keeps the frame alive
        if (state_q == ST_HDR || bus.data_valid) begin
            idle_d = '0;
        end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
            idle_d  = '0;
            state_d = ST_HDR;
            err_d   = 1'b1;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Per-channel write strobes decoded from the executing frame
    always_comb begin
        commit_c    = exec_c && (hdr_q.opcode == OP_COMMIT);
        wr_type_c   = '0;
        wr_freq_c   = '0;
        wr_amp_c    = '0;
        wr_off_c    = '0;
        phase_clr_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (exec_c && (hdr_q.chan == CH_BCAST || hdr_q.chan == 4'(k))) begin
                wr_type_c[k]   = (hdr_q.opcode == OP_TYPE);
                wr_freq_c[k]   = (hdr_q.opcode == OP_FREQ);
                wr_amp_c[k]    = (hdr_q.opcode == OP_AMP);
                wr_off_c[k]    = (hdr_q.opcode == OP_OFFSET);
                phase_clr_c[k] = (hdr_q.opcode == OP_PHRST);
            end
        end
    end

    // Parser registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_HDR;
            hdr_q   <= '0;
            dmsb_q  <= '0;
            dlsb_q  <= '0;
            idle_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            dmsb_q  <= dmsb_d;
            dlsb_q  <= dlsb_d;
            idle_q  <= idle_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        awg_channel #(
            .DATA_W (DATA_W),
            .FREQ_W (FREQ_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .wr_type   (wr_type_c[k]),
            .wr_freq   (wr_freq_c[k]),
            .wr_amp    (wr_amp_c[k]),
            .wr_off    (wr_off_c[k]),
            .wr_data   (cmd_c.data),
            .commit    (commit_c),
            .phase_clr (phase_clr_c[k]),
            .sample    (wave_w[k*DATA_W +: DATA_W]),
            .wrap      (wrap_w[k])
        );
    end

    assign bus.waveform_data = wave_w;
    assign bus.phase_wrap    = wrap_w;
    assign bus.cmd_ack       = ack_q;
    assign bus.frame_err     = err_q;

endmodule

// File: tb/tb_awg_multi_core.sv
// Directed scoreboard bench for awg_multi_core.
module tb_awg_multi_core;
    import awg_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DATA_W = 10;
    localparam int unsigned FREQ_W = 16;
    localparam int unsigned TMO    = 40;
    localparam int unsigned WV_W   = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    awg_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    awg_multi_core #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .FREQ_W      (FREQ_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [1:0]      resp_q[$];
    logic [WV_W-1:0] wave_exp_q[$];
    logic [3:0]      wrap_exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.uart_data  = b;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.uart_data  = 8'h00;
    endtask

    function automatic logic [DATA_W-1:0] ch_out(input int k);
        return bus.waveform_data[k*DATA_W +: DATA_W];
    endfunction

    // Send one frame, queue the expected {ack, err} and check it the next cycle
    task automatic send_frame(input logic [7:0] h, input logic [15:0] d,
                              input bit ok, input bit bad_csum, input string tag);
        logic [7:0] b [FRAME_LEN];
        logic [1:0] e;
        b[0] = h;
        b[1] = d[15:8];
        b[2] = d[7:0];
        b[3] = (h ^ d[15:8] ^ d[7:0]) ^ {7'd0, bad_csum};
        resp_q.push_back({ok, !ok});
        for (int i = 0; i < int'(FRAME_LEN); i++) send_byte(b[i]);
        e = resp_q.pop_front();
        chk({tag, "_ack"}, 64'(bus.cmd_ack), 64'(e[1]));
        chk({tag, "_err"}, 64'(bus.frame_err), 64'(e[0]));
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wave"}, 64'(bus.waveform_data), 64'd0);
        chk({tag, "_wrap"}, 64'(bus.phase_wrap), 64'd0);
        chk({tag, "_ack"}, 64'(bus.cmd_ack), 64'd0);
        chk({tag, "_err"}, 64'(bus.frame_err), 64'd0);
    endtask

    initial begin
        logic [WV_W-1:0] wv;
        logic [1:0]      e;

        rst            = 1'b0;
        bus.uart_data  = 8'h00;
        bus.data_valid = 1'b0;

        // Reset values, during and one cycle after
        ticks(3);
        chk_idle_outputs("rst_during");
        rst = 1'b1;
        tick();
        chk_idle_outputs("rst_after");

        // Ch1 sawtooth, full amplitude, one phase step per cycle
        send_frame(8'h11, 16'h0001, 1'b1, 1'b0, "ch1_type");
        send_frame(8'h31, 16'h03FF, 1'b1, 1'b0, "ch1_amp");
        send_frame(8'h41, 16'h0000, 1'b1, 1'b0, "ch1_off");
        send_frame(8'h21, 16'h4000, 1'b1, 1'b0, "ch1_freq");
        chk("shadow_only_wave", 64'(bus.waveform_data), 64'd0);
        for (int n = 0; n <= 1030; n++) begin
            wv = '0;
            wv[1*DATA_W +: DATA_W] = (n < 2) ? DATA_W'(0) : DATA_W'((n - 2) % 1024);
            wave_exp_q.push_back(wv);
            wrap_exp_q.push_back((n == 1024) ? 4'b0010 : 4'b0000);
        end
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit1");
        for (int n = 0; n <= 1030; n++) begin
            chk("ramp_wave", 64'(bus.waveform_data), 64'(wave_exp_q.pop_front()));
            chk("ramp_wrap", 64'(bus.phase_wrap), 64'(wrap_exp_q.pop_front()));
            tick();
        end

        // Shadow frequency write does not disturb the running ramp until commit
        send_frame(8'h61, 16'h0000, 1'b1, 1'b0, "ph_rst1");
        send_frame(8'h21, 16'h0100, 1'b1, 1'b0, "freq_slow");
        chk("no_commit_c4", 64'(ch_out(1)), 64'd2);
        ticks(6);
        chk("no_commit_c10", 64'(ch_out(1)), 64'd8);
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit2");
        ticks(2);
        chk("slow_c16", 64'(ch_out(1)), 64'd14);
        ticks(63);
        chk("slow_c79", 64'(ch_out(1)), 64'd14);
        tick();
        chk("slow_c80", 64'(ch_out(1)), 64'd15);
        ticks(64);
        chk("slow_c144", 64'(ch_out(1)), 64'd16);

        // Ch0 DC with offset: saturating, then non-saturating
        send_frame(8'h10, 16'h0003, 1'b1, 1'b0, "ch0_type");
        send_frame(8'h30, 16'h03FF, 1'b1, 1'b0, "ch0_amp");
        send_frame(8'h40, 16'h0064, 1'b1, 1'b0, "ch0_off");
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit3");
        ticks(3);
        chk("dc_saturate", 64'(ch_out(0)), 64'd1023);
        send_frame(8'h30, 16'h01FF, 1'b1, 1'b0, "ch0_amp_half");
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit4");
        ticks(3);
        chk("dc_half_plus_off", 64'(ch_out(0)), 64'd611);

        // Bad checksums are rejected and write nothing
        send_frame(8'h21, 16'h0100, 1'b0, 1'b1, "bad_csum_spec");
        send_frame(8'h21, 16'h4000, 1'b0, 1'b1, "bad_csum_fast");
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit5");
        send_frame(8'h61, 16'h0000, 1'b1, 1'b0, "ph_rst2");
        ticks(2);
        chk("keep_freq_c2", 64'(ch_out(1)), 64'd0);
        ticks(63);
        chk("keep_freq_c65", 64'(ch_out(1)), 64'd0);
        tick();
        chk("keep_freq_c66", 64'(ch_out(1)), 64'd1);

        // Illegal channel and undefined opcode; commit ignores chan field
        send_frame(8'h25, 16'h0100, 1'b0, 1'b0, "chan5");
        send_frame(8'h71, 16'h0000, 1'b0, 1'b0, "op7");
        send_frame(8'h05, 16'h0000, 1'b0, 1'b0, "op0");
        send_frame(8'h55, 16'h0000, 1'b1, 1'b0, "commit_chan5");

        // Broadcast configuration, all four channels ramp in lockstep
        send_frame(8'h1F, 16'h0001, 1'b1, 1'b0, "bc_type");
        send_frame(8'h3F, 16'h03FF, 1'b1, 1'b0, "bc_amp");
        send_frame(8'h4F, 16'h0000, 1'b1, 1'b0, "bc_off");
        send_frame(8'h2F, 16'h4000, 1'b1, 1'b0, "bc_freq");
        send_frame(8'h50, 16'h0000, 1'b1, 1'b0, "commit6");
        send_frame(8'h6F, 16'h0000, 1'b1, 1'b0, "bc_ph_rst");
        ticks(2);
        chk("bc_c2", 64'(bus.waveform_data), 64'd0);
        ticks(8);
        wv = '0;
        for (int k = 0; k < int'(NUM_CH); k++) wv[k*DATA_W +: DATA_W] = DATA_W'(8);
        chk("bc_c10", 64'(bus.waveform_data), 64'(wv));
        ticks(1013);
        chk("bc_wrap_c1023", 64'(bus.phase_wrap), 64'd0);
        tick();
        chk("bc_wrap_c1024", 64'(bus.phase_wrap), 64'hF);
        tick();
        chk("bc_wrap_c1025", 64'(bus.phase_wrap), 64'd0);

        // Inter-byte timeout aborts the frame
        send_byte(8'h21);
        send_byte(8'h00);
        send_byte(8'h10);
        resp_q.push_back(2'b01);
        ticks(int'(TMO) - 1);
        chk("tmo_before_err", 64'(bus.frame_err), 64'd0);
        tick();
        e = resp_q.pop_front();
        chk("tmo_ack", 64'(bus.cmd_ack), 64'(e[1]));
        chk("tmo_err", 64'(bus.frame_err), 64'(e[0]));
        tick();
        chk("tmo_err_pulse", 64'(bus.frame_err), 64'd0);
        send_frame(8'h21, 16'h0010, 1'b1, 1'b0, "after_tmo");

        // Final byte landing in the expiry cycle is accepted
        send_byte(8'h22);
        send_byte(8'h00);
        send_byte(8'h10);
        ticks(int'(TMO) - 1);
        resp_q.push_back(2'b10);
        send_byte(8'h22 ^ 8'h00 ^ 8'h10);
        e = resp_q.pop_front();
        chk("expiry_ack", 64'(bus.cmd_ack), 64'(e[1]));
        chk("expiry_err", 64'(bus.frame_err), 64'(e[0]));

        // Reset mid-frame drops the partial frame silently
        send_byte(8'h21);
        send_byte(8'h00);
        rst = 1'b0;
        ticks(2);
        chk_idle_outputs("midrst_during");
        rst = 1'b1;
        tick();
        chk_idle_outputs("midrst_after");
        send_frame(8'h21, 16'h0100, 1'b1, 1'b0, "after_midrst");
        ticks(3);
        chk("midrst_wave", 64'(bus.waveform_data), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
